// File: rtl/rs_issue_select.sv
// Oldest-ready issue selector between the ALU reservation station and the ALU.
// Picks the minimum ROB age relative to the head and registers a one-cycle grant pulse.
module rs_issue_select #(
  parameter int RS_SIZE = 16,
  parameter int RS_W    = 4,
  parameter int ROB_W   = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     _clear,
  input  logic [RS_SIZE-1:0]       _entry_ready,
  input  logic [RS_SIZE*ROB_W-1:0] _entry_rob_id,
  input  logic [ROB_W-1:0]         _rob_head,
  input  logic                     _alu_full,
  output logic                     _issue_valid,
  output logic [RS_W-1:0]          _issue_idx,
  output logic [ROB_W-1:0]         _issue_rob_id,
  output logic [31:0]              _issue_count
);

  // Entry granted last cycle: its ready bit is still set until the RS frees it.
  logic [RS_SIZE-1:0] last_mask;
  logic [RS_SIZE-1:0] cand;
  logic               found;
  logic [RS_W-1:0]    sel;
  logic [ROB_W-1:0]   sel_rob_id;
  logic [ROB_W-1:0]   best_age;
  logic [ROB_W-1:0]   cur_age;
  logic               grant;

  assign cand  = _entry_ready & ~last_mask;
  assign grant = found && !_alu_full;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    found      = 1'b0;
    sel        = '0;
    sel_rob_id = '0;
    best_age   = '0;
    cur_age    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      // Modular distance from the head makes the comparison wrap-safe.
      cur_age = _entry_rob_id[i*ROB_W +: ROB_W] - _rob_head;
      // Strict less-than keeps the lowest index on equal ages.
      if (cand[i] && (!found || cur_age < best_age)) begin
        found      = 1'b1;
        sel        = RS_W'(i);
        sel_rob_id = _entry_rob_id[i*ROB_W +: ROB_W];
        best_age   = cur_age;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      _issue_valid  <= 1'b0;
      _issue_idx    <= '0;
      _issue_rob_id <= '0;
      _issue_count  <= '0;
      last_mask     <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        _issue_valid <= 1'b0;
        _issue_count <= '0;
        last_mask    <= '0;
      end else if (grant) begin
        _issue_valid  <= 1'b1;
        _issue_idx    <= sel;
        _issue_rob_id <= sel_rob_id;
        _issue_count  <= _issue_count + 32'd1;
        last_mask     <= {{(RS_SIZE-1){1'b0}}, 1'b1} << sel;
      end else begin
        _issue_valid <= 1'b0;
        last_mask    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: reset, age order, ROB wrap, no double issue,
// back-pressure, pause hold and flush.
module tb_rs_issue_select;

  localparam int RS_SIZE = 16;
  localparam int RS_W    = 4;
  localparam int ROB_W   = 5;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     clear;
  logic [RS_SIZE-1:0]       entry_ready;
  logic [RS_SIZE*ROB_W-1:0] entry_rob_id;
  logic [ROB_W-1:0]         rob_head;
  logic                     alu_full;
  logic                     issue_valid;
  logic [RS_W-1:0]          issue_idx;
  logic [ROB_W-1:0]         issue_rob_id;
  logic [31:0]              issue_count;

  int n_cmp  = 0;
  int n_fail = 0;

  rs_issue_select #(.RS_SIZE(RS_SIZE), .RS_W(RS_W), .ROB_W(ROB_W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    ._clear       (clear),
    ._entry_ready (entry_ready),
    ._entry_rob_id(entry_rob_id),
    ._rob_head    (rob_head),
    ._alu_full    (alu_full),
    ._issue_valid (issue_valid),
    ._issue_idx   (issue_idx),
    ._issue_rob_id(issue_rob_id),
    ._issue_count (issue_count)
  );

  always #5 clk_in = ~clk_in;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_rob(input int idx, input logic [ROB_W-1:0] id);
    entry_rob_id[idx*ROB_W +: ROB_W] = id;
  endtask

  // Compare {valid, idx, rob_id} against an expected triple.
  task automatic expect_pulse(input string name, input logic v, input logic [RS_W-1:0] idx,
                              input logic [ROB_W-1:0] rob);
    n_cmp++;
    if ({issue_valid, issue_idx, issue_rob_id} !== {v, idx, rob}) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b idx=%0d rob=%0d, want valid=%0b idx=%0d rob=%0d",
               name, issue_valid, issue_idx, issue_rob_id, v, idx, rob);
    end
  endtask

  task automatic expect_valid(input string name, input logic v);
    n_cmp++;
    if (issue_valid !== v) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b, want %0b", name, issue_valid, v);
    end
  endtask

  task automatic expect_count(input string name, input logic [31:0] c);
    n_cmp++;
    if (issue_count !== c) begin
      n_fail++;
      $display("FAIL %s: got count=%0d, want %0d", name, issue_count, c);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; alu_full = 1'b0;
    rob_head = '0; entry_rob_id = '0; entry_ready = '1;
    step();
    expect_pulse("reset_c1", 1'b0, 4'd0, 5'd0);
    expect_count("reset_c1_count", 32'd0);
    step();
    expect_pulse("reset_c2", 1'b0, 4'd0, 5'd0);
    expect_count("reset_c2_count", 32'd0);
    rst_in = 1'b0;
    step();
    expect_pulse("reset_first_grant", 1'b1, 4'd0, 5'd0);
    expect_count("reset_first_count", 32'd1);
    entry_ready = '0;
    step();
    expect_valid("reset_idle", 1'b0);
    clear = 1'b1;
    step();
    expect_count("reset_clear_count", 32'd0);
    clear = 1'b0;
  endtask

  task automatic test_age_select();
    rob_head = 5'd0;
    set_rob(3, 5'd7); set_rob(5, 5'd2); set_rob(9, 5'd2);
    entry_ready = 16'h0228;
    step();
    expect_pulse("age_g1", 1'b1, 4'd5, 5'd2);
    step();
    expect_pulse("age_g2", 1'b1, 4'd9, 5'd2);
    entry_ready[5] = 1'b0;
    step();
    expect_pulse("age_g3", 1'b1, 4'd3, 5'd7);
    entry_ready[9] = 1'b0;
    step();
    expect_valid("age_idle", 1'b0);
    expect_count("age_count", 32'd3);
    entry_ready[3] = 1'b0;
  endtask

  task automatic test_wrap();
    rob_head = 5'd28;
    set_rob(0, 5'd1); set_rob(1, 5'd30);
    entry_ready = 16'h0003;
    step();
    expect_pulse("wrap_g1", 1'b1, 4'd1, 5'd30);
    step();
    expect_pulse("wrap_g2", 1'b1, 4'd0, 5'd1);
    entry_ready[1] = 1'b0;
    step();
    expect_valid("wrap_idle", 1'b0);
    entry_ready[0] = 1'b0;
    expect_count("wrap_count", 32'd5);
  endtask

  task automatic test_no_double();
    rob_head = 5'd0;
    set_rob(4, 5'd3);
    entry_ready = 16'h0010;
    step();
    expect_pulse("nodbl_pulse", 1'b1, 4'd4, 5'd3);
    step();
    expect_valid("nodbl_masked", 1'b0);
    entry_ready[4] = 1'b0;
    step();
    expect_valid("nodbl_freed", 1'b0);
    expect_count("nodbl_count", 32'd6);
  endtask

  task automatic test_back_pressure();
    set_rob(2, 5'd10); set_rob(6, 5'd4);
    entry_ready = 16'h0044;
    alu_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_valid($sformatf("bp_full_%0d", i), 1'b0);
    end
    expect_count("bp_full_count", 32'd6);
    alu_full = 1'b0;
    step();
    expect_pulse("bp_g1", 1'b1, 4'd6, 5'd4);
    step();
    expect_pulse("bp_g2", 1'b1, 4'd2, 5'd10);
    entry_ready[6] = 1'b0;
    step();
    expect_valid("bp_idle", 1'b0);
    entry_ready[2] = 1'b0;
    expect_count("bp_count", 32'd8);
  endtask

  task automatic test_pause();
    set_rob(7, 5'd9);
    entry_ready = 16'h0080;
    step();
    expect_pulse("pause_pulse", 1'b1, 4'd7, 5'd9);
    rdy_in = 1'b0;
    entry_ready[8] = 1'b1;
    set_rob(8, 5'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_pulse($sformatf("pause_hold_%0d", i), 1'b1, 4'd7, 5'd9);
    end
    expect_count("pause_count", 32'd9);
    entry_ready[8] = 1'b0;
    rdy_in = 1'b1;
    // last_mask was held across the pause, so entry 7 stays blocked.
    step();
    expect_valid("pause_resume_masked", 1'b0);
    entry_ready[7] = 1'b0;
  endtask

  task automatic test_flush();
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_rob(0, 5'd12); set_rob(1, 5'd12);
    entry_ready = 16'h0003;
    for (int i = 0; i < 5; i++) step();
    expect_pulse("flush_pre", 1'b1, 4'd0, 5'd12);
    expect_count("flush_pre_count", 32'd5);
    entry_ready = 16'h0001;
    clear = 1'b1;
    step();
    expect_pulse("flush_drop", 1'b0, 4'd0, 5'd12);
    expect_count("flush_count", 32'd0);
    clear = 1'b0;
    step();
    expect_pulse("flush_regrant", 1'b1, 4'd0, 5'd12);
    expect_count("flush_regrant_count", 32'd1);
    entry_ready = '0;
  endtask

  initial begin
    test_reset();
    test_age_select();
    test_wrap();
    test_no_double();
    test_back_pressure();
    test_pause();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
